// File: rtl/dmem_sized.sv
// Byte-addressed little-endian data memory with sized loads/stores, sign/zero extension,
// misalignment detection and a configurable read latency exposed through ready_o.
module dmem_sized #(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       dato_i,
    input  logic              memwrite_i,
    input  logic              memread_i,
    input  logic [1:0]        size_i,
    input  logic              unsigned_i,
    output logic [31:0]       dato_o,
    output logic              ready_o,
    output logic              misalign_o
);

    localparam int unsigned Words   = 2 ** (ADDR_W - 2);
    localparam int unsigned CntInit = (RD_LATENCY >= 2) ? RD_LATENCY - 2 : 0;

    logic [31:0]       mem [Words];
    logic [ADDR_W-3:0] word_idx;
    logic [1:0]        byte_off;
    logic              misalign;
    logic              store_ok;
    logic              load_ok;
    logic              idle;
    logic [3:0]        byte_en;
    logic [31:0]       wdata;
    logic [31:0]       rword;
    logic [7:0]        byte_val;
    logic [15:0]       half_val;
    logic [31:0]       ext;

    assign word_idx = addr_i[ADDR_W-1:2];
    assign byte_off = addr_i[1:0];

    always_comb begin
        misalign = 1'b0;
        case (size_i)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = addr_i[0];
            2'b10:   misalign = |addr_i[1:0];
            default: misalign = 1'b1;
        endcase
    end

    assign misalign_o = misalign;
    assign store_ok   = memwrite_i & ~misalign;
    // A simultaneous store wins; the read side is dropped entirely.
    assign load_ok    = memread_i & ~memwrite_i & ~misalign;

    always_comb begin
        byte_en = 4'b0000;
        wdata   = dato_i;
        case (size_i)
            2'b00: begin
                byte_en           = 4'b0000;
                byte_en[byte_off] = 1'b1;
                wdata             = {4{dato_i[7:0]}};
            end
            2'b01: begin
                byte_en = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{dato_i[15:0]}};
            end
            2'b10: begin
                byte_en = 4'b1111;
                wdata   = dato_i;
            end
            default: begin
                byte_en = 4'b0000;
                wdata   = dato_i;
            end
        endcase
    end

    // Storage is deliberately left without reset.
    always_ff @(posedge clk_i) begin
        if (store_ok && idle) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) begin
                    mem[word_idx][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    assign rword    = mem[word_idx];
    assign byte_val = rword[8*byte_off +: 8];
    assign half_val = addr_i[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        ext = rword;
        case (size_i)
            2'b00:   ext = unsigned_i ? {24'h0, byte_val} : {{24{byte_val[7]}}, byte_val};
            2'b01:   ext = unsigned_i ? {16'h0, half_val} : {{16{half_val[15]}}, half_val};
            default: ext = rword;
        endcase
    end

    if (RD_LATENCY == 0) begin : g_comb
        assign idle    = 1'b1;
        assign ready_o = 1'b1;
        assign dato_o  = load_ok ? ext : 32'h0;
    end else begin : g_fsm
        typedef enum logic [1:0] {StIdle, StWait, StDone} state_t;

        state_t      state_q, state_d;
        logic [2:0]  cnt_q, cnt_d;
        logic [31:0] rdata_q, rdata_d;

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                state_q <= StIdle;
                cnt_q   <= 3'd0;
                rdata_q <= 32'h0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                rdata_q <= rdata_d;
            end
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            rdata_d = rdata_q;
            ready_o = 1'b1;
            dato_o  = 32'h0;
            case (state_q)
                StIdle: begin
                    if (load_ok) begin
                        ready_o = 1'b0;
                        rdata_d = ext;
                        state_d = (RD_LATENCY == 1) ? StDone : StWait;
                        cnt_d   = 3'(CntInit);
                    end
                end
                StWait: begin
                    ready_o = 1'b0;
                    if (cnt_q == 3'd0) begin
                        state_d = StDone;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end
                StDone: begin
                    dato_o  = rdata_q;
                    state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end

        assign idle = (state_q == StIdle);
    end

endmodule

// File: tb/tb_dmem_sized.sv
// Directed bench for dmem_sized: a RD_LATENCY=3 instance for the stalled path and a
// RD_LATENCY=0 instance for the combinational path.
module tb_dmem_sized;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        a_rst, a_we, a_re, a_uns, a_ready, a_mis;
    logic [7:0]  a_addr;
    logic [31:0] a_wdata, a_rdata;
    logic [1:0]  a_size;

    logic        z_rst, z_we, z_re, z_uns, z_ready, z_mis;
    logic [7:0]  z_addr;
    logic [31:0] z_wdata, z_rdata;
    logic [1:0]  z_size;

    dmem_sized #(.ADDR_W(8), .RD_LATENCY(3)) u_lat3 (
        .clk_i(clk), .rst_i(a_rst), .addr_i(a_addr), .dato_i(a_wdata),
        .memwrite_i(a_we), .memread_i(a_re), .size_i(a_size), .unsigned_i(a_uns),
        .dato_o(a_rdata), .ready_o(a_ready), .misalign_o(a_mis)
    );

    dmem_sized #(.ADDR_W(8), .RD_LATENCY(0)) u_lat0 (
        .clk_i(clk), .rst_i(z_rst), .addr_i(z_addr), .dato_i(z_wdata),
        .memwrite_i(z_we), .memread_i(z_re), .size_i(z_size), .unsigned_i(z_uns),
        .dato_o(z_rdata), .ready_o(z_ready), .misalign_o(z_mis)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_store(input logic [7:0] addr, input logic [31:0] data, input logic [1:0] size);
        a_addr = addr; a_wdata = data; a_size = size; a_we = 1'b1; a_re = 1'b0;
        step();
        a_we = 1'b0;
    endtask

    task automatic z_store(input logic [7:0] addr, input logic [31:0] data, input logic [1:0] size);
        z_addr = addr; z_wdata = data; z_size = size; z_we = 1'b1; z_re = 1'b0;
        step();
        z_we = 1'b0;
    endtask

    // Presents a load until ready_o is seen; lat is the cycle index of ready, -1 on timeout.
    task automatic a_load(input logic [7:0] addr, input logic [1:0] size, input logic uns,
                          output logic [31:0] data, output int lat);
        a_addr = addr; a_size = size; a_uns = uns; a_re = 1'b1; a_we = 1'b0;
        lat = -1; data = 32'h0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (a_ready && lat < 0) begin
                lat  = c;
                data = a_rdata;
            end
            step();
            if (lat >= 0) break;
        end
        a_re = 1'b0;
    endtask

    task automatic test_reset();
        a_rst = 1'b1; z_rst = 1'b1;
        step(); step();
        @(negedge clk);
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", a_ready); end
        total++; if (a_rdata !== 32'h0) begin bad++; $display("FAIL reset_dato got=%h want=0", a_rdata); end
        total++; if (a_mis !== 1'b0) begin bad++; $display("FAIL reset_misalign got=%b want=0", a_mis); end
        total++; if (z_rdata !== 32'h0) begin bad++; $display("FAIL reset_z_dato got=%h want=0", z_rdata); end
        step();
        a_rst = 1'b0; z_rst = 1'b0;
    endtask

    task automatic test_word_byte();
        logic [31:0] d; int lat;
        a_store(8'h10, 32'h11223344, 2'b10);
        a_store(8'h11, 32'h000000AB, 2'b00);
        a_load(8'h10, 2'b10, 1'b0, d, lat);
        total++; if (d !== 32'h1122AB44) begin bad++; $display("FAIL word_byte got=%h want=1122ab44", d); end
        total++; if (lat !== 3) begin bad++; $display("FAIL word_byte_lat got=%0d want=3", lat); end
    endtask

    task automatic test_extension();
        logic [31:0] d; int lat;
        a_store(8'h20, 32'h0000F080, 2'b10);
        a_load(8'h20, 2'b01, 1'b0, d, lat);
        total++; if (d !== 32'hFFFFF080) begin bad++; $display("FAIL half_signed got=%h want=fffff080", d); end
        a_load(8'h21, 2'b00, 1'b1, d, lat);
        total++; if (d !== 32'h000000F0) begin bad++; $display("FAIL byte_unsigned got=%h want=000000f0", d); end
        a_load(8'h20, 2'b00, 1'b0, d, lat);
        total++; if (d !== 32'hFFFFFF80) begin bad++; $display("FAIL byte_signed got=%h want=ffffff80", d); end
        a_load(8'h20, 2'b01, 1'b1, d, lat);
        total++; if (d !== 32'h0000F080) begin bad++; $display("FAIL half_unsigned got=%h want=0000f080", d); end
        a_store(8'h22, 32'h00008001, 2'b01);
        a_load(8'h20, 2'b10, 1'b0, d, lat);
        total++; if (d !== 32'h8001F080) begin bad++; $display("FAIL half_store got=%h want=8001f080", d); end
        a_load(8'h22, 2'b01, 1'b0, d, lat);
        total++; if (d !== 32'hFFFF8001) begin bad++; $display("FAIL upper_half got=%h want=ffff8001", d); end
    endtask

    task automatic test_misalign();
        logic [31:0] d; int lat;
        a_addr = 8'h23; a_size = 2'b01; a_wdata = 32'h0000BEEF; a_we = 1'b1; a_re = 1'b0;
        @(negedge clk);
        total++; if (a_mis !== 1'b1) begin bad++; $display("FAIL mis_half_store got=%b want=1", a_mis); end
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL mis_half_ready got=%b want=1", a_ready); end
        step();
        a_we = 1'b0; a_addr = 8'h22; a_size = 2'b10; a_re = 1'b1;
        @(negedge clk);
        total++; if (a_mis !== 1'b1) begin bad++; $display("FAIL mis_word_load got=%b want=1", a_mis); end
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL mis_word_ready got=%b want=1", a_ready); end
        total++; if (a_rdata !== 32'h0) begin bad++; $display("FAIL mis_word_dato got=%h want=0", a_rdata); end
        step();
        @(negedge clk);
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL mis_fsm_idle got=%b want=1", a_ready); end
        step();
        a_addr = 8'h24; a_size = 2'b11;
        @(negedge clk);
        total++; if (a_mis !== 1'b1) begin bad++; $display("FAIL mis_reserved got=%b want=1", a_mis); end
        step();
        a_re = 1'b0;
        a_load(8'h20, 2'b10, 1'b0, d, lat);
        total++; if (d !== 32'h8001F080) begin bad++; $display("FAIL mis_unchanged got=%h want=8001f080", d); end
    endtask

    task automatic test_latency();
        logic        exp_rdy;
        logic [31:0] exp_d;
        a_addr = 8'h10; a_size = 2'b10; a_uns = 1'b0; a_re = 1'b1; a_we = 1'b0;
        for (int c = 0; c < 5; c++) begin
            exp_rdy = (c >= 3);
            exp_d   = (c == 3) ? 32'h1122AB44 : 32'h0;
            @(negedge clk);
            total++;
            if (a_ready !== exp_rdy || a_rdata !== exp_d) begin
                bad++;
                $display("FAIL latency_c%0d got ready=%b dato=%h want ready=%b dato=%h",
                         c, a_ready, a_rdata, exp_rdy, exp_d);
            end
            step();
            if (c == 3) a_re = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic        exp_rdy;
        logic [31:0] exp_d;
        a_addr = 8'h10; a_size = 2'b10; a_uns = 1'b0; a_re = 1'b1;
        for (int c = 0; c < 8; c++) begin
            exp_rdy = (c == 3 || c == 7);
            exp_d   = (c == 3) ? 32'h1122AB44 : (c == 7) ? 32'h8001F080 : 32'h0;
            @(negedge clk);
            total++;
            if (a_ready !== exp_rdy || a_rdata !== exp_d) begin
                bad++;
                $display("FAIL b2b_c%0d got ready=%b dato=%h want ready=%b dato=%h",
                         c, a_ready, a_rdata, exp_rdy, exp_d);
            end
            step();
            if (c == 3) a_addr = 8'h20;
        end
        a_re = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; int lat;
        a_addr = 8'h20; a_size = 2'b10; a_uns = 1'b0; a_re = 1'b1;
        @(negedge clk);
        total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL rmid_stall got=%b want=0", a_ready); end
        step();
        a_rst = 1'b1; a_re = 1'b0;
        step();
        a_rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (a_ready !== 1'b1 || a_rdata !== 32'h0) begin
                bad++;
                $display("FAIL rmid_after_c%0d got ready=%b dato=%h want ready=1 dato=0",
                         c, a_ready, a_rdata);
            end
            step();
        end
        a_load(8'h10, 2'b10, 1'b0, d, lat);
        total++; if (d !== 32'h1122AB44) begin bad++; $display("FAIL rmid_reload got=%h want=1122ab44", d); end
        total++; if (lat !== 3) begin bad++; $display("FAIL rmid_reload_lat got=%0d want=3", lat); end
    endtask

    task automatic test_highest_and_priority();
        logic [31:0] d; int lat;
        a_store(8'hFC, 32'hCAFEBABE, 2'b10);
        a_load(8'hFC, 2'b10, 1'b0, d, lat);
        total++; if (d !== 32'hCAFEBABE) begin bad++; $display("FAIL top_word got=%h want=cafebabe", d); end
        a_load(8'hFF, 2'b00, 1'b1, d, lat);
        total++; if (d !== 32'h000000CA) begin bad++; $display("FAIL top_byte got=%h want=000000ca", d); end
        a_load(8'hFE, 2'b01, 1'b0, d, lat);
        total++; if (d !== 32'hFFFFCAFE) begin bad++; $display("FAIL top_half got=%h want=ffffcafe", d); end
        a_addr = 8'h30; a_size = 2'b10; a_wdata = 32'h55AA00FF; a_we = 1'b1; a_re = 1'b1;
        @(negedge clk);
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL prio3_ready got=%b want=1", a_ready); end
        total++; if (a_rdata !== 32'h0) begin bad++; $display("FAIL prio3_dato got=%h want=0", a_rdata); end
        step();
        a_we = 1'b0; a_re = 1'b0;
        a_load(8'h30, 2'b10, 1'b0, d, lat);
        total++; if (d !== 32'h55AA00FF) begin bad++; $display("FAIL prio3_store got=%h want=55aa00ff", d); end
    endtask

    task automatic test_zero_latency();
        z_store(8'h40, 32'hDEADBEEF, 2'b10);
        z_addr = 8'h40; z_size = 2'b10; z_uns = 1'b0; z_re = 1'b1;
        @(negedge clk);
        total++; if (z_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL z_word got=%h want=deadbeef", z_rdata); end
        total++; if (z_ready !== 1'b1) begin bad++; $display("FAIL z_ready got=%b want=1", z_ready); end
        step();
        z_addr = 8'h43; z_size = 2'b00; z_uns = 1'b1;
        @(negedge clk);
        total++; if (z_rdata !== 32'h000000DE) begin bad++; $display("FAIL z_byte_u got=%h want=000000de", z_rdata); end
        step();
        z_addr = 8'h41; z_uns = 1'b0;
        @(negedge clk);
        total++; if (z_rdata !== 32'hFFFFFFBE) begin bad++; $display("FAIL z_byte_s got=%h want=ffffffbe", z_rdata); end
        step();
        z_addr = 8'h40; z_size = 2'b10; z_wdata = 32'h12345678; z_we = 1'b1; z_re = 1'b1;
        @(negedge clk);
        total++; if (z_rdata !== 32'h0) begin bad++; $display("FAIL z_prio_dato got=%h want=0", z_rdata); end
        total++; if (z_ready !== 1'b1) begin bad++; $display("FAIL z_prio_ready got=%b want=1", z_ready); end
        step();
        z_we = 1'b0;
        @(negedge clk);
        total++; if (z_rdata !== 32'h12345678) begin bad++; $display("FAIL z_raw got=%h want=12345678", z_rdata); end
        step();
        z_re = 1'b0;
        @(negedge clk);
        total++; if (z_rdata !== 32'h0) begin bad++; $display("FAIL z_idle_dato got=%h want=0", z_rdata); end
        step();
    endtask

    initial begin
        a_rst = 1'b0; a_we = 1'b0; a_re = 1'b0; a_uns = 1'b0;
        a_addr = 8'h0; a_wdata = 32'h0; a_size = 2'b10;
        z_rst = 1'b0; z_we = 1'b0; z_re = 1'b0; z_uns = 1'b0;
        z_addr = 8'h0; z_wdata = 32'h0; z_size = 2'b10;
        test_reset();
        test_word_byte();
        test_extension();
        test_misalign();
        test_latency();
        test_back_to_back();
        test_reset_mid();
        test_highest_and_priority();
        test_zero_latency();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
